// File: rtl/top.sv
// Single-cycle RV32I-subset CPU with instruction ROM, register file and data RAM.
// Latency: one instruction committed per clk rising edge; fetch and loads are combinational.
// Backpressure: none; the core never stalls.

module top_irom #(
  parameter int DEPTH = 256
) (
  input  logic [31:0] addr_i,
  output logic [31:0] dat_o
);
  localparam int AW = $clog2(DEPTH);

  // Loaded only from outside (e.g. by a bench); no reset, no write port.
  reg [31:0] mem [0:DEPTH-1];

  logic [29:0] widx;
  logic        unused_bits;

  assign widx        = addr_i[31:2] % 30'(DEPTH);
  assign unused_bits = ^{widx[29:AW], addr_i[1:0]};
  assign dat_o       = mem[widx[AW-1:0]];
endmodule

module top_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdat1_o,
  output logic [31:0] rdat2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdat_i
);
  logic [31:0] regs [0:31];

  // Write port; reset clears every register asynchronously and x0 is never written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs[waddr_i] <= wdat_i;
    end
  end

  assign rdat1_o = (raddr1_i == 5'd0) ? 32'd0 : regs[raddr1_i];
  assign rdat2_o = (raddr2_i == 5'd0) ? 32'd0 : regs[raddr2_i];
endmodule

module top_dram #(
  parameter int DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdat_i,
  output logic [31:0] rdat_o
);
  localparam int AW = $clog2(DEPTH);

  reg [31:0] mem [0:DEPTH-1];

  logic [29:0] widx;
  logic        unused_bits;

  assign widx        = addr_i[31:2] % 30'(DEPTH);
  assign unused_bits = ^{widx[29:AW], addr_i[1:0]};
  assign rdat_o      = mem[widx[AW-1:0]];

  // Word store; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[widx[AW-1:0]] <= wdat_i;
  end
endmodule

module top_cpu #(
  parameter int IROM_DEPTH = 256,
  parameter int DRAM_DEPTH = 256
) (
  input  logic clk_i,
  input  logic rst_ni
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst;
  logic [31:0] rs1_dat, rs2_dat;
  logic        rf_we;
  logic [31:0] rf_wdat;
  logic        dm_we;
  logic [31:0] dm_addr, dm_rdat;

  top_irom #(.DEPTH(IROM_DEPTH)) u_d_irom (.addr_i(pc_q), .dat_o(inst));

  wire [6:0] opcode = inst[6:0];
  wire [4:0] rd     = inst[11:7];
  wire [2:0] f3     = inst[14:12];
  wire [4:0] rs1    = inst[19:15];
  wire [4:0] rs2    = inst[24:20];
  wire [6:0] f7     = inst[31:25];

  wire [31:0] imm_i = {{20{inst[31]}}, inst[31:20]};
  wire [31:0] imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  wire [31:0] imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  wire [31:0] imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  wire [31:0] imm_u = {inst[31:12], 12'd0};
  wire [31:0] pc_plus4 = pc_q + 32'd4;

  top_regfile u_regfile (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .raddr1_i(rs1),
    .raddr2_i(rs2),
    .rdat1_o (rs1_dat),
    .rdat2_o (rs2_dat),
    .we_i    (rf_we),
    .waddr_i (rd),
    .wdat_i  (rf_wdat)
  );

  // The fetched word may be a store while reset is held; block it there.
  top_dram #(.DEPTH(DRAM_DEPTH)) u_dram (
    .clk_i (clk_i),
    .we_i  (dm_we & rst_ni),
    .addr_i(dm_addr),
    .wdat_i(rs2_dat),
    .rdat_o(dm_rdat)
  );

  // Decode/execute: anything not recognised (including unsupported funct fields) is a NOP.
  always_comb begin
    pc_d    = pc_plus4;
    rf_we   = 1'b0;
    rf_wdat = '0;
    dm_we   = 1'b0;
    dm_addr = rs1_dat + imm_i;
    case (opcode)
      OP_LUI: begin
        rf_we   = 1'b1;
        rf_wdat = imm_u;
      end
      OP_JAL: begin
        rf_we   = 1'b1;
        rf_wdat = pc_plus4;
        pc_d    = pc_q + imm_j;
      end
      OP_BRANCH: begin
        if ((f3 == 3'b000 && rs1_dat == rs2_dat) || (f3 == 3'b001 && rs1_dat != rs2_dat))
          pc_d = pc_q + imm_b;
      end
      OP_LOAD: begin
        if (f3 == 3'b010) begin
          rf_we   = 1'b1;
          rf_wdat = dm_rdat;
        end
      end
      OP_STORE: begin
        dm_addr = rs1_dat + imm_s;
        dm_we   = (f3 == 3'b010);
      end
      OP_IMM: begin
        rf_we = 1'b1;
        case (f3)
          3'b000:  rf_wdat = rs1_dat + imm_i;
          3'b010:  rf_wdat = {31'd0, $signed(rs1_dat) < $signed(imm_i)};
          3'b100:  rf_wdat = rs1_dat ^ imm_i;
          3'b110:  rf_wdat = rs1_dat | imm_i;
          3'b111:  rf_wdat = rs1_dat & imm_i;
          default: rf_we   = 1'b0;
        endcase
      end
      OP_REG: begin
        rf_we = 1'b1;
        case ({f7, f3})
          10'b0000000_000: rf_wdat = rs1_dat + rs2_dat;
          10'b0100000_000: rf_wdat = rs1_dat - rs2_dat;
          10'b0000000_010: rf_wdat = {31'd0, $signed(rs1_dat) < $signed(rs2_dat)};
          10'b0000000_100: rf_wdat = rs1_dat ^ rs2_dat;
          10'b0000000_110: rf_wdat = rs1_dat | rs2_dat;
          10'b0000000_111: rf_wdat = rs1_dat & rs2_dat;
          default:         rf_we   = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // Program counter; reset pulls it to 0 immediately, dropping the in-flight instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= '0;
    else         pc_q <= pc_d;
  end
endmodule

module top #(
  parameter int IROM_DEPTH = 256,
  parameter int DRAM_DEPTH = 256
) (
  input logic clk,
  input logic rst_n
);
  top_cpu #(.IROM_DEPTH(IROM_DEPTH), .DRAM_DEPTH(DRAM_DEPTH)) u_cpu (
    .clk_i (clk),
    .rst_ni(rst_n)
  );
endmodule

// File: tb/tb_top.sv
// Directed bench for the single-cycle CPU: program table plus reset sequences.
// Each program runs from a fresh reset for a fixed cycle count, then one value is checked.
// No handshakes; all observation is hierarchical.

module tb_top;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  top #(.IROM_DEPTH(256), .DRAM_DEPTH(256)) dut (.clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  // kind: 0 = register, 1 = PC, 2 = data RAM word
  typedef struct {
    string            name;
    logic [7:0][31:0] prog;
    int               ncyc;
    int               kind;
    int               idx;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, int ncyc, int kind, int idx, logic [31:0] exp,
                              logic [31:0] w0, logic [31:0] w1 = 0, logic [31:0] w2 = 0,
                              logic [31:0] w3 = 0, logic [31:0] w4 = 0, logic [31:0] w5 = 0);
    vec_t v;
    v.name = n; v.ncyc = ncyc; v.kind = kind; v.idx = idx; v.exp = exp;
    v.prog = '0;
    v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2;
    v.prog[3] = w3; v.prog[4] = w4; v.prog[5] = w5;
    return v;
  endfunction

  function automatic logic [31:0] observe(int kind, int idx);
    if (kind == 0)      return dut.u_cpu.u_regfile.regs[idx];
    else if (kind == 1) return dut.u_cpu.pc_q;
    else                return dut.u_cpu.u_dram.mem[idx];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) dut.u_cpu.u_d_irom.mem[i] = 32'h0;
  endtask

  task automatic run_vec(vec_t v);
    @(negedge clk);
    rst_n = 1'b0;
    clear_rom();
    for (int i = 0; i < 8; i++) dut.u_cpu.u_d_irom.mem[i] = v.prog[i];
    @(negedge clk);
    rst_n = 1'b1;
    repeat (v.ncyc) @(posedge clk);
    @(negedge clk);
    check(v.name, observe(v.kind, v.idx), v.exp);
  endtask

  initial begin
    logic all_zero;

    // arithmetic wrap and signed compare
    vecs.push_back(mk("lui_x1",     3, 0, 1, 32'h80000000, 32'h800000B7, 32'hFFF08113, 32'h0020A1B3));
    vecs.push_back(mk("addi_wrap",  3, 0, 2, 32'h7FFFFFFF, 32'h800000B7, 32'hFFF08113, 32'h0020A1B3));
    vecs.push_back(mk("slt_signed", 3, 0, 3, 32'h00000001, 32'h800000B7, 32'hFFF08113, 32'h0020A1B3));
    // memory round trip
    vecs.push_back(mk("sw_mem2",    3, 2, 2, 32'h00000055, 32'h05500093, 32'h00102423, 32'h00802103));
    vecs.push_back(mk("lw_x2",      3, 0, 2, 32'h00000055, 32'h05500093, 32'h00102423, 32'h00802103));
    // branches
    vecs.push_back(mk("beq_skip_x1", 2, 0, 1, 32'h0,  32'h00000463, 32'h00100093, 32'h00200113));
    vecs.push_back(mk("beq_tgt_x2",  2, 0, 2, 32'h2,  32'h00000463, 32'h00100093, 32'h00200113));
    vecs.push_back(mk("beq_pc",      2, 1, 0, 32'hC,  32'h00000463, 32'h00100093, 32'h00200113));
    vecs.push_back(mk("bne_fall_x1", 2, 0, 1, 32'h1,  32'h00001463, 32'h00100093, 32'h00200113));
    vecs.push_back(mk("bne_pc",      2, 1, 0, 32'h8,  32'h00001463, 32'h00100093, 32'h00200113));
    vecs.push_back(mk("jal_link",    5, 0, 1, 32'h14, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFDFF0EF));
    vecs.push_back(mk("jal_pc",      5, 1, 0, 32'h0C, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFDFF0EF));
    // x0 and undefined opcode
    vecs.push_back(mk("x0_write",   1, 0, 0, 32'h0, 32'h00900013));
    vecs.push_back(mk("x0_pc",      1, 1, 0, 32'h4, 32'h00900013));
    vecs.push_back(mk("undef_pc",   2, 1, 0, 32'h8, 32'h00500093, 32'h00000000));
    vecs.push_back(mk("undef_keep", 2, 0, 1, 32'h5, 32'h00500093, 32'h00000000));
    // logic ops, sub, slti
    vecs.push_back(mk("xori", 6, 0, 2, 32'h0F,  32'h0F000093, 32'h0FF0C113, 32'h03C0F193, 32'h00F0E213, 32'h402082B3, 32'hFFF0A313));
    vecs.push_back(mk("andi", 6, 0, 3, 32'h30,  32'h0F000093, 32'h0FF0C113, 32'h03C0F193, 32'h00F0E213, 32'h402082B3, 32'hFFF0A313));
    vecs.push_back(mk("ori",  6, 0, 4, 32'hFF,  32'h0F000093, 32'h0FF0C113, 32'h03C0F193, 32'h00F0E213, 32'h402082B3, 32'hFFF0A313));
    vecs.push_back(mk("sub",  6, 0, 5, 32'hE1,  32'h0F000093, 32'h0FF0C113, 32'h03C0F193, 32'h00F0E213, 32'h402082B3, 32'hFFF0A313));
    vecs.push_back(mk("slti", 6, 0, 6, 32'h0,   32'h0F000093, 32'h0FF0C113, 32'h03C0F193, 32'h00F0E213, 32'h402082B3, 32'hFFF0A313));
    vecs.push_back(mk("add_wrap", 2, 0, 2, 32'h0, 32'hFFF00093, 32'h00108113));

    // ROM loaded while reset is held, released at 160 ns
    #2 rst_n = 1'b0;
    #38;
    clear_rom();
    dut.u_cpu.u_d_irom.mem[0] = 32'h00500093;
    dut.u_cpu.u_d_irom.mem[1] = 32'h00700113;
    dut.u_cpu.u_d_irom.mem[2] = 32'h002081B3;
    #60;
    check("rst_pc", dut.u_cpu.pc_q, 32'h0);
    check("rst_x1", dut.u_cpu.u_regfile.regs[1], 32'h0);
    #60;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("boot_x1", dut.u_cpu.u_regfile.regs[1], 32'd5);
    check("boot_x2", dut.u_cpu.u_regfile.regs[2], 32'd7);
    check("boot_x3", dut.u_cpu.u_regfile.regs[3], 32'd12);

    foreach (vecs[i]) run_vec(vecs[i]);

    // mid-run reset: addi xk,x0,k for k = 1..8
    @(negedge clk);
    rst_n = 1'b0;
    clear_rom();
    for (int k = 1; k <= 8; k++)
      dut.u_cpu.u_d_irom.mem[k-1] = (k << 20) | (k << 7) | 32'h13;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_pre_x5", dut.u_cpu.u_regfile.regs[5], 32'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", dut.u_cpu.pc_q, 32'h0);
    all_zero = 1'b1;
    for (int r = 1; r < 32; r++)
      if (dut.u_cpu.u_regfile.regs[r] !== 32'h0) all_zero = 1'b0;
    check("mid_rst_regs_zero", {31'd0, all_zero}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart_x1", dut.u_cpu.u_regfile.regs[1], 32'd1);
    check("restart_x2", dut.u_cpu.u_regfile.regs[2], 32'd0);
    check("restart_pc", dut.u_cpu.pc_q, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter IROM_DEPTH, default 256, instruction ROM depth in 32-bit words.
REQ-002 Parameter DRAM_DEPTH, default 256, data RAM depth in 32-bit words.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have no other ports; all observation is hierarchical.

Function
REQ-006 Top SHALL instantiate a CPU as u_cpu; u_cpu SHALL contain the instruction ROM instance u_d_irom, whose storage is a reg [31:0] array named mem, index 0..IROM_DEPTH-1.
REQ-007 u_d_irom.mem SHALL NOT be cleared or written by reset or by the CPU; a bench loads it with $readmemh at any time, including while rst_n=0.
REQ-008 The CPU SHALL be single-cycle, executing exactly one instruction per clk cycle, with no stalls.
REQ-009 Instruction fetch: word address PC[31:2] modulo IROM_DEPTH, combinational read.
REQ-010 The ISA SHALL be the RV32I subset LUI, JAL, BEQ, BNE, LW, SW, ADDI, ANDI, ORI, XORI, SLTI, ADD, SUB, AND, OR, XOR, SLT, with standard encodings.
REQ-011 The register file SHALL be u_cpu.u_regfile.regs, 32 x 32 bit; x0 reads 0 and writes to it are discarded.
REQ-012 The register file SHALL have two combinational read ports and one write port committed on the rising edge.
REQ-013 Arithmetic SHALL be 32-bit two's complement; overflow wraps and no trap is raised.
REQ-014 SLT/SLTI SHALL compare as signed values; immediates SHALL be sign-extended per RV32I.
REQ-015 Next PC: PC+4 by default.
REQ-016 Taken BEQ/BNE SHALL load PC+B-imm; JAL SHALL load PC+J-imm and write PC+4 to rd.
REQ-017 The data RAM SHALL be u_cpu.u_dram.mem, DRAM_DEPTH x 32, word-addressed by addr[31:2] modulo depth.
REQ-018 LW SHALL read combinationally; SW SHALL write on the rising edge; byte and half accesses are not supported.
REQ-019 Any undefined opcode SHALL execute as a NOP (PC+4, no state change).
REQ-020 The PC SHALL wrap modulo 2^32; fetch wraps modulo IROM_DEPTH.

Reset
REQ-021 While rst_n=0, PC SHALL be 0x00000000 and no register-file or data-RAM write SHALL occur.
REQ-022 Registers x1..x31 SHALL be cleared to 0 asynchronously on reset assertion; data RAM contents are not reset.
REQ-023 Reset assertion mid-program SHALL immediately force PC=0, and the in-flight instruction SHALL NOT commit.
REQ-024 The first instruction, mem[0], SHALL commit on the first rising edge after rst_n rises.

Verification
REQ-025 ROM load during reset -> load mem with "addi x1,x0,5; addi x2,x0,7; add x3,x1,x2" at t=40 ns, release rst_n at 160 ns -> after 3 edges x1=5, x2=7, x3=12.
REQ-026 Arithmetic wrap and compare -> "lui x1,0x80000; addi x2,x1,-1" -> x2=0x7FFFFFFF; "slt x3,x1,x2" -> x3=1.
REQ-027 Memory round-trip -> "addi x1,x0,0x55; sw x1,8(x0); lw x2,8(x0)" -> dram mem[2]=0x55, x2=0x55.
REQ-028 Branches -> "beq x0,x0,+8" skips the next word; "bne x0,x0,+8" falls through; "jal x1,-4" at PC=0x10 -> x1=0x14, PC=0x0C.
REQ-029 Register x0 -> "addi x0,x0,9" leaves x0=0; an undefined word (0x00000000) advances PC by 4.
REQ-030 Mid-run reset -> assert rst_n=0 after 5 instructions -> PC=0 and x1..x31=0 immediately; on release, execution restarts at mem[0].
